// File: rtl/sram_block_master.sv
// Command-driven Avalon-MM master: fill, copy and sum over a word-addressed SRAM.
// One transfer in flight at a time; all master outputs are registered.
module sram_block_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic [DATA_W-1:0]   cmd_pattern,
  input  logic                cmd_abort,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [DATA_W-1:0]   result,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  input  logic                avm_waitrequest
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH
  } state_t;

  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
  localparam logic [1:0] OP_RSV  = 2'b11;

  state_t              state_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   src_q, dst_q, addr_q;
  logic [ADDR_W:0]     cnt_q;
  logic [DATA_W-1:0]   pat_q, wdata_q, res_q;
  logic                busy_q, done_q, abt_q;
  logic                cs_q, rd_q, wr_q;
  logic                last;

  assign last = (cnt_q == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            src_q  <= cmd_src;
            dst_q  <= cmd_dst;
            cnt_q  <= cmd_len;
            pat_q  <= cmd_pattern;
            res_q  <= '0;
            abt_q  <= 1'b0;
            busy_q <= 1'b1;
            if (cmd_len == '0 || cmd_op == OP_RSV) begin
              state_q <= FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (cmd_op == OP_FILL) begin
              state_q <= WR_REQ;
              cs_q    <= 1'b1;
              wr_q    <= 1'b1;
              addr_q  <= cmd_dst;
              wdata_q <= cmd_pattern;
            end else begin
              state_q <= RD_REQ;
              cs_q    <= 1'b1;
              rd_q    <= 1'b1;
              addr_q  <= cmd_src;
            end
          end
        end
        RD_REQ: begin
          if (!avm_waitrequest) begin
            cs_q    <= 1'b0;
            rd_q    <= 1'b0;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (avm_readdatavalid) begin
            if (op_q == OP_COPY) begin
              if (cmd_abort) begin
                state_q <= FINISH;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                abt_q   <= 1'b1;
              end else begin
                state_q <= WR_REQ;
                cs_q    <= 1'b1;
                wr_q    <= 1'b1;
                addr_q  <= dst_q;
                wdata_q <= avm_readdata;
              end
            end else begin
              res_q <= res_q + avm_readdata;
              cnt_q <= cnt_q - 1'b1;
              src_q <= src_q + 1'b1;
              if (last || cmd_abort) begin
                state_q <= FINISH;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                abt_q   <= !last;
              end else begin
                state_q <= RD_REQ;
                cs_q    <= 1'b1;
                rd_q    <= 1'b1;
                addr_q  <= src_q + 1'b1;
              end
            end
          end
        end
        WR_REQ: begin
          if (!avm_waitrequest) begin
            cnt_q <= cnt_q - 1'b1;
            dst_q <= dst_q + 1'b1;
            if (op_q == OP_COPY) src_q <= src_q + 1'b1;
            if (last || cmd_abort) begin
              state_q <= FINISH;
              cs_q    <= 1'b0;
              wr_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              abt_q   <= !last;
            end else if (op_q == OP_COPY) begin
              state_q <= RD_REQ;
              wr_q    <= 1'b0;
              rd_q    <= 1'b1;
              addr_q  <= src_q + 1'b1;
            end else begin
              addr_q <= dst_q + 1'b1;
            end
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = abt_q;
  assign result         = res_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = {(DATA_W/8){cs_q}};

endmodule

// File: doc/sram_block_master.md
SRAM_BLOCK_MASTER -- requirements
Module: sram_block_master

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the SRAM slave port.
REQ-002 Parameter DATA_W, default 32, data width; byte lanes = DATA_W/8.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offer; accepted when cmd_valid & cmd_ready.
REQ-006 cmd_ready  output  1  high only in IDLE.
REQ-007 cmd_op  input  2  00 = fill, 01 = copy, 10 = sum, 11 = reserved.
REQ-008 cmd_src  input  ADDR_W  source word address (copy, sum).
REQ-009 cmd_dst  input  ADDR_W  destination word address (fill, copy).
REQ-010 cmd_len  input  ADDR_W+1  word count, 0..2^ADDR_W.
REQ-011 cmd_pattern  input  DATA_W  fill value.
REQ-012 cmd_abort  input  1  level request to stop the current command early.
REQ-013 busy  output  1  high from command accept until done.
REQ-014 done  output  1  one-cycle pulse at command completion.
REQ-015 aborted  output  1  valid with done; 1 = command ended by cmd_abort.
REQ-016 result  output  DATA_W  sum result, held until next accept.
REQ-017 avm_address  output  ADDR_W  Avalon-MM word address.
REQ-018 avm_chipselect, avm_read, avm_write  output  1 each  Avalon-MM controls.
REQ-019 avm_byteenable  output  DATA_W/8  all ones during any transfer.
REQ-020 avm_writedata  output  DATA_W  write data.
REQ-021 avm_readdata  input  DATA_W; avm_readdatavalid  input  1; avm_waitrequest  input  1.

Function
REQ-022 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
REQ-023 Accept in IDLE: latch op/src/dst/len/pattern, clear result, set busy; len=0 or op=11 -> FINISH, else fill -> WR_REQ, copy/sum -> RD_REQ.
REQ-024 RD_REQ: assert avm_read & avm_chipselect with address = src pointer; hold all master outputs stable while avm_waitrequest=1; on waitrequest=0 go RD_WAIT.
REQ-025 RD_WAIT: deassert read; wait for avm_readdatavalid; capture readdata into data register; copy -> WR_REQ, sum -> add to result (mod 2^DATA_W), decrement count, increment src.
REQ-026 WR_REQ: assert avm_write & avm_chipselect, address = dst pointer, writedata = pattern (fill) or data register (copy); on waitrequest=0 decrement count, increment dst (and src for copy).
REQ-027 Exactly one transfer outstanding; never read and write in the same cycle.
REQ-028 After a transfer completes: count=0 -> FINISH; else next RD_REQ (copy/sum) or WR_REQ (fill), with no idle cycle between transfers.
REQ-029 Pointers wrap modulo 2^ADDR_W (1023 + 1 -> 0).
REQ-030 FINISH: one cycle, done=1, busy=0 thereafter, return to IDLE; cmd_ready high the following cycle.
REQ-031 cmd_abort sampled only at a transfer boundary: the in-flight transfer (including pending readdatavalid) always completes; copy abort after read skips the write; then FINISH with aborted=1.
REQ-032 cmd_abort in IDLE is ignored; cmd_valid while busy is ignored (not queued).
REQ-033 Copy with overlapping regions proceeds in ascending address order, no hazard handling.

Reset
REQ-034 While reset_n=0: state IDLE, cmd_ready=1, busy=0, done=0, aborted=0, result=0, avm_read=avm_write=avm_chipselect=0, avm_address=0, avm_writedata=0.
REQ-035 Reset assertion mid-transfer drops the transfer immediately; no completion pulse after release.

Verification
REQ-036 Fill dst=0x010, len=4, pattern=0xDEADBEEF, waitrequest=0 -> writes at 0x010..0x013, 4 consecutive write cycles, done 1 cycle after last write, aborted=0.
REQ-037 Copy src=0x3FE, dst=0x100, len=3 with memory model latency 1 -> reads 0x3FE,0x3FF,0x000; writes 0x100..0x102 with matching data.
REQ-038 Sum src=0x020, len=3, data 0xFFFFFFFF, 2, 5 -> result=0x00000006, done pulse, result held.
REQ-039 Fill len=2 with waitrequest high 3 cycles on first write -> address/writedata stable 4 cycles, exactly 2 writes total.
REQ-040 Copy len=8, cmd_abort raised during 3rd read wait -> 2 words copied, no 3rd write, done with aborted=1.
REQ-041 cmd_len=0 -> no Avalon activity, done 1 cycle after accept; reset_n pulse mid-fill -> all outputs at reset values, no done.
